uart_word_rx: RTL and testbench
===============================

# uart_word_rx

Parametrised UART word receiver. It oversamples a serial line at 16x baud, checks each frame, and assembles NBYTES consecutive bytes into one WORD_BITS-wide word, most significant byte first. The word is presented on a valid/ready handshake. It is the generalised successor of the fixed 381-bit receive path and feeds the wide-operand datapath. It adds frame-error, overrun and inter-byte-timeout detection.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- BAUD, 115200, line rate; DIV = round(CLK_HZ/(16*BAUD)), must be ≥ 2
- WORD_BITS, 381, assembled word width; NBYTES = ceil(WORD_BITS/8)
- TIMEOUT_BITS, 64, max idle bit-times between bytes of one word
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  receiver enable
- RxD  input  1  serial line, idle high, asynchronous
- RxData  output  WORD_BITS  assembled word
- word_valid  output  1  RxData holds an unconsumed word
- word_ready  input  1  consumer accepts word
- byte_count  output  clog2(NBYTES+1)  bytes of current partial word
- frame_err  output  1  one-cycle pulse: bad stop (or parity) bit
- overrun  output  1  one-cycle pulse: completed word dropped
- timeout  output  1  one-cycle pulse: partial word discarded on gap

## Operation
- RxD passes through a 2-flop synchroniser; both flops reset to 1. The tick counter runs 0..DIV-1 and emits one tick per wrap.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE → START when synced RxD = 0; the sample counter clears.
- START: after 8 ticks, RxD = 0 → DATA. RxD = 1 → IDLE (glitch; no flag).
- DATA: samples every 16 ticks, LSB first, 8 bits.
- STOP: samples after 16 ticks.
  - Sample = 1: byte commits into buffer bits [(NBYTES-1-byte_count)*8 +: 8], byte_count increments, FSM → IDLE.
  - Sample = 0: frame_err pulses, the byte and the partial word are discarded, byte_count → 0, FSM → WAIT_HIGH.
- WAIT_HIGH → IDLE on the first synced RxD = 1.
- Word completion: byte_count reaches NBYTES. Buffer[WORD_BITS-1:0] loads into RxData and word_valid sets. Upper pad bits are dropped. byte_count and buffer clear.
- Completion while word_valid = 1 and word_ready = 0: overrun pulses, the new word is dropped, and the held word is unchanged.
- Timeout: an idle-tick counter runs in IDLE while byte_count ≠ 0. When it reaches TIMEOUT_BITS*16, the partial word is cleared and timeout pulses. The counter clears on every start bit.
- enable = 0: the FSM forces to IDLE immediately, even mid-byte, and the partial word and byte_count clear. RxData and word_valid are retained and the handshake keeps operating. No flags pulse.

## Timing
- Reset values: RxData = 0, word_valid = 0, byte_count = 0, all flags 0, FSM IDLE, tick and timeout counters 0.
- Reset mid-frame aborts with no flag.
- Byte commit happens on the edge of the stop-bit sample. On completion, RxData and word_valid update on the next edge, so latency is 1 clk.
- Stop is sampled at bit midpoint and the FSM returns to IDLE there, so back-to-back frames with one stop bit are received.
- Handshake: a word transfers on an edge where word_valid && word_ready. word_valid drops the following cycle unless a new word completes.
- Completion in the same cycle as acceptance: the new word loads, word_valid stays 1, no overrun.
- Flags are registered and exactly 1 clk wide. frame_err and timeout cannot coincide.

## Configuration
- PARITY_EN defined:
  - a PARITY state follows DATA and samples one bit 16 ticks after the last data bit;
  - even parity over data plus parity bit is checked;
  - a mismatch is treated exactly as a bad stop bit: frame_err pulses, the partial word is discarded, FSM → WAIT_HIGH.
- PARITY_EN undefined: the PARITY state and checker are absent and frames are 8N1.

## Test plan
- Reset, then WORD_BITS=16, DIV=4, frames 0xA5 and 0x3C with word_ready=1 → RxData = 0xA53C, single word_valid pulse, byte_count 0→1→0.
- Default WORD_BITS=381, 48 bytes of 0xFF → RxData all ones, word_valid 1, pad bits absent.
- WORD_BITS=16, word_ready=0, send 4 bytes 11 22 33 44 → RxData = 0x1122, overrun pulses once on completion of the second word, word_valid stays 1.
- Stop bit forced 0 on the 2nd byte of a 16-bit word → frame_err pulse, byte_count → 0, FSM stays in WAIT_HIGH until the line is high. Next two good bytes 0xBEEF → RxData = 0xBEEF.
- TIMEOUT_BITS=4: send one byte, then idle ≥ 64 ticks → timeout pulse, byte_count 0. A subsequent 2-byte word assembles correctly.
- 0.5-bit-wide low glitch on RxD → no byte, no flags. With PARITY_EN, wrong parity → frame_err.

Source files
------------

// File: rtl/uart_word_rx.sv
// uart_word_rx: 16x-oversampled UART receiver that packs NBYTES bytes, MSB first, into a
// WORD_BITS word on a valid/ready handshake. Define PARITY_EN for even-parity (8E1) frames.
module uart_word_rx #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int BAUD         = 115200,
   parameter int WORD_BITS    = 381,
   parameter int TIMEOUT_BITS = 64,
   localparam int NBYTES      = (WORD_BITS + 7) / 8,
   localparam int BC_W        = $clog2(NBYTES + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 RxD,
   output logic [WORD_BITS-1:0] RxData,
   output logic                 word_valid,
   input  logic                 word_ready,
   output logic [BC_W-1:0]      byte_count,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 timeout
);

   localparam int DIV      = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
   localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TO_LIMIT = TIMEOUT_BITS * 16;
   localparam int TO_W     = $clog2(TO_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_HIGH
   } state_t;

   state_t               state_reg, state_next;
   logic                 sync1_reg, sync2_reg;
   logic [DIV_W-1:0]     div_cnt_reg;
   logic [3:0]           samp_cnt_reg, samp_cnt_next;
   logic [2:0]           bit_cnt_reg, bit_cnt_next;
   logic [7:0]           shift_reg, shift_next;
   logic [WORD_BITS-1:0] buf_reg;
   logic [WORD_BITS-1:0] rx_data_reg;
   logic                 word_valid_reg;
   logic [BC_W-1:0]      byte_count_reg;
   logic                 frame_err_reg, overrun_reg, timeout_reg;
   logic [TO_W-1:0]      idle_cnt_reg;

   logic                 rx_s, tick, commit, bad_frame, word_done, to_hit;
   logic [NBYTES-1:0]    byte_wr;
   logic [WORD_BITS-1:0] buf_load, buf_din;

   assign rx_s      = sync2_reg;
   assign tick      = (div_cnt_reg == DIV_W'(DIV - 1));
   assign word_done = (byte_count_reg == BC_W'(NBYTES));
   assign to_hit    = enable && tick && (state_reg == IDLE) && (byte_count_reg != '0) && !word_done
                      && (idle_cnt_reg == TO_W'(TO_LIMIT - 1));

   // Byte slot gi is the gi-th byte received; slot 0 lands in the most significant byte.
   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_slot
      assign byte_wr[gi] = commit && (byte_count_reg == BC_W'(gi));
   end

   // Only the low WORD_BITS of the padded byte buffer are kept, so pad bits never exist.
   for (genvar gi = 0; gi < WORD_BITS; gi++) begin : g_bit
      assign buf_load[gi] = byte_wr[NBYTES - 1 - gi / 8];
      assign buf_din[gi]  = shift_reg[gi % 8];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg   <= 1'b1;
         sync2_reg   <= 1'b1;
         div_cnt_reg <= '0;
      end else begin
         sync1_reg   <= RxD;
         sync2_reg   <= sync1_reg;
         div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         samp_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         samp_cnt_reg <= samp_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      samp_cnt_next = samp_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      commit        = 1'b0;
      bad_frame     = 1'b0;
      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!rx_s) begin
                  state_next    = START;
                  samp_cnt_next = '0;
               end
            end
            START: begin
               if (tick) begin
                  samp_cnt_next = samp_cnt_reg + 4'd1;
                  if (samp_cnt_reg == 4'd7) begin
                     samp_cnt_next = '0;
                     bit_cnt_next  = '0;
                     state_next    = rx_s ? IDLE : DATA;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  samp_cnt_next = samp_cnt_reg + 4'd1;
                  if (samp_cnt_reg == 4'd15) begin
                     shift_next   = {rx_s, shift_reg[7:1]};
                     bit_cnt_next = bit_cnt_reg + 3'd1;
                     if (bit_cnt_reg == 3'd7) begin
`ifdef PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                     end
                  end
               end
            end
`ifdef PARITY_EN
            PARITY: begin
               if (tick) begin
                  samp_cnt_next = samp_cnt_reg + 4'd1;
                  if (samp_cnt_reg == 4'd15) begin
                     if (^{shift_reg, rx_s}) begin
                        bad_frame  = 1'b1;
                        state_next = WAIT_HIGH;
                     end else begin
                        state_next = STOP;
                     end
                  end
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  samp_cnt_next = samp_cnt_reg + 4'd1;
                  if (samp_cnt_reg == 4'd15) begin
                     if (rx_s) begin
                        commit     = 1'b1;
                        state_next = IDLE;
                     end else begin
                        bad_frame  = 1'b1;
                        state_next = WAIT_HIGH;
                     end
                  end
               end
            end
            WAIT_HIGH: begin
               if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Counts idle ticks only while a partial word is pending; any start bit restarts it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_cnt_reg <= '0;
      end else if (!enable || state_reg != IDLE || byte_count_reg == '0 || to_hit) begin
         idle_cnt_reg <= '0;
      end else if (tick) begin
         idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_reg        <= '0;
         byte_count_reg <= '0;
         rx_data_reg    <= '0;
         word_valid_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         overrun_reg    <= 1'b0;
         timeout_reg    <= 1'b0;
      end else begin
         frame_err_reg <= bad_frame;
         overrun_reg   <= 1'b0;
         timeout_reg   <= 1'b0;
         if (word_valid_reg && word_ready) word_valid_reg <= 1'b0;
         if (word_done) begin
            // An accept on this same edge frees the output register for the new word.
            if (word_valid_reg && !word_ready) begin
               overrun_reg <= 1'b1;
            end else begin
               rx_data_reg    <= buf_reg;
               word_valid_reg <= 1'b1;
            end
            buf_reg        <= '0;
            byte_count_reg <= '0;
         end else if (!enable || bad_frame) begin
            buf_reg        <= '0;
            byte_count_reg <= '0;
         end else if (commit) begin
            buf_reg        <= (buf_reg & ~buf_load) | (buf_din & buf_load);
            byte_count_reg <= byte_count_reg + BC_W'(1);
         end else if (to_hit) begin
            buf_reg        <= '0;
            byte_count_reg <= '0;
            timeout_reg    <= 1'b1;
         end
      end
   end

   assign RxData     = rx_data_reg;
   assign word_valid = word_valid_reg;
   assign byte_count = byte_count_reg;
   assign frame_err  = frame_err_reg;
   assign overrun    = overrun_reg;
   assign timeout    = timeout_reg;

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: a 16-bit instance (TIMEOUT_BITS=4) and a default 381-bit
// instance, both at DIV=4. Define PARITY_EN for both RTL and bench to cover parity frames.
module tb_uart_word_rx;
   localparam int CLK_HZ   = 64;
   localparam int BAUD     = 1;
   localparam int DIV      = 4;
   localparam int BIT_CLKS = 16 * DIV;
   localparam int OK       = 0;
   localparam int BAD_STOP = 1;
`ifdef PARITY_EN
   localparam int EXP_FE   = 2;
`else
   localparam int EXP_FE   = 1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        en_a, rxd_a, ready_a, valid_a, fe_a, ov_a, to_a;
   logic [15:0] data_a;
   logic [1:0]  bc_a;
   logic         en_b, rxd_b, ready_b, valid_b, fe_b, ov_b, to_b;
   logic [380:0] data_b;
   logic [5:0]   bc_b;
   logic [380:0] all_ones;

   uart_word_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WORD_BITS(16), .TIMEOUT_BITS(4)) dut_a (
      .clk(clk), .reset(reset), .enable(en_a), .RxD(rxd_a), .RxData(data_a),
      .word_valid(valid_a), .word_ready(ready_a), .byte_count(bc_a),
      .frame_err(fe_a), .overrun(ov_a), .timeout(to_a));

   uart_word_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut_b (
      .clk(clk), .reset(reset), .enable(en_b), .RxD(rxd_b), .RxData(data_b),
      .word_valid(valid_b), .word_ready(ready_b), .byte_count(bc_b),
      .frame_err(fe_b), .overrun(ov_b), .timeout(to_b));

   int errors = 0;
   int checks = 0;
   int fe_n = 0, ov_n = 0, to_n = 0, vr_n = 0;
   int fe_hi = 0, ov_hi = 0, to_hi = 0, b_flag_hi = 0;
   logic fe_q = 1'b0, ov_q = 1'b0, to_q = 1'b0, valid_q = 1'b0;
   int s_fe, s_ov, s_to, s_vr;
   logic found;

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs [4];

   always @(negedge clk) begin
      if (fe_a) fe_hi++;
      if (ov_a) ov_hi++;
      if (to_a) to_hi++;
      if (fe_a && !fe_q) fe_n++;
      if (ov_a && !ov_q) ov_n++;
      if (to_a && !to_q) to_n++;
      if (valid_a && !valid_q) vr_n++;
      if (fe_b || ov_b || to_b) b_flag_hi++;
      fe_q = fe_a; ov_q = ov_a; to_q = to_a; valid_q = valid_a;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion before it");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [380:0] act, input logic [380:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic snap();
      s_fe = fe_n; s_ov = ov_n; s_to = to_n; s_vr = vr_n;
   endtask

   task automatic drive(input bit sel, input logic v);
      if (sel) rxd_b = v;
      else     rxd_a = v;
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] b, input int err);
      drive(sel, 1'b0);
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive(sel, b[i]);
         repeat (BIT_CLKS) @(negedge clk);
      end
`ifdef PARITY_EN
      drive(sel, (^b) ^ (err == 2));
      repeat (BIT_CLKS) @(negedge clk);
`endif
      drive(sel, err != BAD_STOP);
      repeat (BIT_CLKS) @(negedge clk);
      if (err == BAD_STOP) repeat (2 * BIT_CLKS) @(negedge clk);
      drive(sel, 1'b1);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 8'h3C, 16'hA53C};
      vecs[1] = '{8'h00, 8'hFF, 16'h00FF};
      vecs[2] = '{8'h80, 8'h01, 16'h8001};
      vecs[3] = '{8'h5A, 8'hC3, 16'h5AC3};
      all_ones = '1;

      reset = 1'b1; en_a = 1'b1; en_b = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1;
      ready_a = 1'b1; ready_b = 1'b0;
      repeat (3) @(negedge clk);
      check("reset RxData", data_a, 0);
      check("reset word_valid", valid_a, 0);
      check("reset byte_count", bc_a, 0);
      check("reset flags", {fe_a, ov_a, to_a}, 0);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check("idle after reset", {valid_a, bc_a, fe_a, ov_a, to_a, valid_b, bc_b}, 0);
      $display("reset: RxData=%04h valid=%0b byte_count=%0d", data_a, valid_a, bc_a);

      // Table-driven two-byte words with the consumer always ready.
      for (int v = 0; v < 4; v++) begin
         snap();
         check("vec byte_count before", bc_a, 0);
         send_byte(0, vecs[v].b0, OK);
         check("vec byte_count after 1st", bc_a, 1);
         send_byte(0, vecs[v].b1, OK);
         check("vec RxData", data_a, vecs[v].exp);
         check("vec valid pulses", vr_n - s_vr, 1);
         check("vec valid consumed", valid_a, 0);
         check("vec byte_count after word", bc_a, 0);
         check("vec no flags", (fe_n - s_fe) + (ov_n - s_ov) + (to_n - s_to), 0);
         $display("vec %0d: bytes %02h %02h -> RxData=%04h", v, vecs[v].b0, vecs[v].b1, data_a);
         repeat (8) @(negedge clk);
      end

      // Overrun: consumer stalled across two complete words.
      ready_a = 1'b0;
      snap();
      send_byte(0, 8'h11, OK);
      send_byte(0, 8'h22, OK);
      check("stall RxData", data_a, 16'h1122);
      check("stall valid", valid_a, 1);
      send_byte(0, 8'h33, OK);
      send_byte(0, 8'h44, OK);
      check("overrun count", ov_n - s_ov, 1);
      check("overrun RxData held", data_a, 16'h1122);
      check("overrun valid held", valid_a, 1);
      $display("overrun: sent 11 22 33 44 -> RxData=%04h overruns=%0d", data_a, ov_n - s_ov);

      // Completion on the same edge as acceptance: load, stay valid, no overrun.
      snap();
      send_byte(0, 8'h55, OK);
      fork
         send_byte(0, 8'h66, OK);
         begin
            found = 1'b0;
            for (int c = 0; c < 20 * BIT_CLKS && !found; c++) begin
               @(negedge clk);
               if (bc_a == 2'd2) found = 1'b1;
            end
            check("same-cycle completion seen", found, 1);
            ready_a = 1'b1;
            @(negedge clk);
            check("same-cycle valid", valid_a, 1);
            check("same-cycle RxData", data_a, 16'h5566);
            check("same-cycle no overrun", ov_n - s_ov, 0);
            @(negedge clk);
            check("same-cycle drained", valid_a, 0);
         end
      join
      $display("same-cycle accept: RxData=%04h", data_a);
      repeat (8) @(negedge clk);

      // Bad stop on the second byte, line held low, then a good word.
      snap();
      send_byte(0, 8'hAA, OK);
      send_byte(0, 8'h77, BAD_STOP);
      check("frame_err count", fe_n - s_fe, 1);
      check("frame_err byte_count", bc_a, 0);
      check("frame_err no word", vr_n - s_vr, 0);
      repeat (8) @(negedge clk);
      send_byte(0, 8'hBE, OK);
      send_byte(0, 8'hEF, OK);
      check("after frame_err RxData", data_a, 16'hBEEF);
      check("after frame_err one word", vr_n - s_vr, 1);
      $display("frame error: AA + bad stop, then BE EF -> RxData=%04h", data_a);
      repeat (8) @(negedge clk);

      // Inter-byte timeout with TIMEOUT_BITS=4 (64 ticks).
      snap();
      send_byte(0, 8'h12, OK);
      check("timeout partial", bc_a, 1);
      repeat (200) @(negedge clk);
      check("timeout not early", to_n - s_to, 0);
      check("timeout partial kept", bc_a, 1);
      for (int c = 0; c < 300 && to_n == s_to; c++) @(negedge clk);
      check("timeout count", to_n - s_to, 1);
      check("timeout byte_count", bc_a, 0);
      send_byte(0, 8'hCA, OK);
      send_byte(0, 8'hFE, OK);
      check("after timeout RxData", data_a, 16'hCAFE);
      $display("timeout: 12 dropped, then CA FE -> RxData=%04h", data_a);

      // Low glitch just under half a bit: rejected in START.
      snap();
      rxd_a = 1'b0;
      repeat (7 * DIV) @(negedge clk);
      rxd_a = 1'b1;
      repeat (3 * BIT_CLKS) @(negedge clk);
      check("glitch byte_count", bc_a, 0);
      check("glitch no events", (fe_n - s_fe) + (to_n - s_to) + (vr_n - s_vr), 0);
      $display("glitch: byte_count=%0d", bc_a);

      // Enable dropped mid-byte with a partial word pending.
      snap();
      send_byte(0, 8'h01, OK);
      fork
         send_byte(0, 8'h00, OK);
         begin
            repeat (200) @(negedge clk);
            en_a = 1'b0;
         end
      join
      check("disable byte_count", bc_a, 0);
      check("disable RxData kept", data_a, 16'hCAFE);
      check("disable no events", (fe_n - s_fe) + (to_n - s_to) + (vr_n - s_vr), 0);
      en_a = 1'b1;
      repeat (8) @(negedge clk);
      $display("disable: byte_count=%0d RxData=%04h", bc_a, data_a);

`ifdef PARITY_EN
      snap();
      send_byte(0, 8'h5A, 2);
      check("parity frame_err", fe_n - s_fe, 1);
      check("parity byte_count", bc_a, 0);
      repeat (8) @(negedge clk);
      $display("parity: bad parity on 5A -> frame_err");
`endif

      // Full-width default instance: 48 bytes of FF, consumer stalled.
      for (int i = 0; i < 48; i++) begin
         send_byte(1, 8'hFF, OK);
         if (i == 46) check("wide byte_count 47", bc_b, 47);
      end
      repeat (4) @(negedge clk);
      check("wide RxData", data_b, all_ones);
      check("wide valid", valid_b, 1);
      check("wide byte_count", bc_b, 0);
      check("wide no flags", b_flag_hi, 0);
      $display("wide: 48 x FF -> valid=%0b RxData all ones=%0b", valid_b, data_b == all_ones);

      check("frame_err cycles total", fe_hi, EXP_FE);
      check("overrun cycles total", ov_hi, 1);
      check("timeout cycles total", to_hi, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
